merge_2to1_stream: RTL and testbench
====================================

Name: merge_2to1_stream

Overview:
- Sorting-tree leaf merge stage that sits directly upstream of the coupler.
- Consumes two ascending-sorted P_WIDTH record streams, each held in a first-word-fall-through FIFO.
- Emits one merged ascending P_WIDTH stream into the coupler's input FIFO.
- Streams are delimited by an all-zero record (terminator). Real records are non-zero. Each pair of input runs produces one merged run followed by exactly one zero.

Parameters:
- P_WIDTH, 128, record width in bits; whole record is the unsigned compare key.
- CNT_WIDTH, 32, width of the completed-run counter.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_a_data  in  P_WIDTH  head record of input FIFO A; valid when i_a_empty=0.
- i_a_empty  in  1  FIFO A empty.
- o_a_deq  out  1  pop FIFO A at this edge; combinational.
- i_b_data  in  P_WIDTH  head record of input FIFO B.
- i_b_empty  in  1  FIFO B empty.
- o_b_deq  out  1  pop FIFO B; combinational.
- o_data  out  P_WIDTH  output record; registered.
- o_enq  out  1  push o_data downstream this cycle.
- i_full  in  1  downstream FIFO full.
- o_run_cnt  out  CNT_WIDTH  number of terminators emitted since reset; wraps.

Behaviour:
- Output register: holds out_vld and o_data.
  - o_enq = out_vld & ~i_full; o_data is held stable until o_enq.
  - ld = ~out_vld | o_enq.
  - A record is selected and a pop issued only in a cycle where ld=1 and a selection exists.
  - The selected record enters the register at that edge. Latency: input pop to o_enq is 1 cycle when i_full=0.
  - No record is ever dropped or duplicated.
- A head is "zero" when i_a_data==0 and i_a_empty=0; same for B.
- State MERGE (reset state):
  - Both empty, or exactly one empty: no selection, wait.
  - Both non-zero: select the smaller. Tie selects A. Pop only the selected side.
  - A zero, B non-zero: no pop, go DRAIN_B.
  - B zero, A non-zero: no pop, go DRAIN_A.
  - Both zero: select zero, pop both, o_run_cnt+1 when loaded, stay MERGE.
- State DRAIN_B (A's terminator is parked at A's head, not popped):
  - Ignores i_a_empty/i_a_data.
  - B non-zero: select B, pop B.
  - B zero: select zero, pop A and B in the same cycle, count+1, go MERGE.
  - B empty: wait.
- State DRAIN_A: mirror of DRAIN_B.
- State changes on zero detection in MERGE happen regardless of ld. Drain steps require ld.
- o_run_cnt increments when the terminator is loaded into the output register. It wraps modulo 2^CNT_WIDTH.
- i_full held high indefinitely: the register holds, no further pops, state frozen except the MERGE→DRAIN transitions.
- Reset (any cycle, including mid-run, with i_full=1, or with a held record):
  - out_vld=0, o_data=0, o_enq=0, state=MERGE, o_run_cnt=0.
  - o_a_deq=o_b_deq=0 while i_rst=1. The held record is discarded.
- Input records not terminated by zero are never flushed; this is the caller's responsibility.

Test Plan:
- Merge: A={1,4,7,0}, B={2,3,9,0}, i_full=0 → o_data sequence 1,2,3,4,7,9,0; o_run_cnt=1; first o_enq 1 cycle after first pop.
- Ties and uneven runs: A={5,5,0}, B={5,0} → 5(A),5(A),5(B),0. Then A={0}, B={8,0} → 8,0; o_run_cnt=2. A's zero pops in the same cycle as B's zero.
- Drain with A FIFO empty after its terminator: A={3,0} then empty, B={1,6,10,0} → 1,3,6,10,0; no stall while A empty in DRAIN_B.
- Backpressure: A={1,2,0}, B={0}, i_full=1 for 5 cycles after the first load → o_enq=0, o_data holds 1, no further pops; release → 2,0 with no loss or duplicate.
- Empty runs: A={0}, B={0} → single 0 output, both popped in one cycle, o_run_cnt increments by 1.
- Reset mid-run with record held and i_full=1 → next cycle o_enq=0, o_data=0, o_run_cnt=0, state MERGE; fresh runs merge correctly afterwards.

Source files
------------

// File: rtl/merge_2to1_stream_if.sv
// Stream bundle for the 2:1 merge stage: two FWFT FIFO read ports in, one FIFO write port out.
// The merge block is the master; the FIFOs around it form the slave side.
interface merge_2to1_stream_if #(
  parameter int P_WIDTH = 128
);
  logic [P_WIDTH-1:0] a_data;
  logic               a_empty;
  logic               a_deq;
  logic [P_WIDTH-1:0] b_data;
  logic               b_empty;
  logic               b_deq;
  logic [P_WIDTH-1:0] data;
  logic               enq;
  logic               full;

  modport master (
    input  a_data, a_empty, b_data, b_empty, full,
    output a_deq, b_deq, data, enq
  );

  modport slave (
    output a_data, a_empty, b_data, b_empty, full,
    input  a_deq, b_deq, data, enq
  );
endinterface

// File: rtl/merge_2to1_stream.sv
// Sorting-tree leaf merge: combines two ascending zero-terminated runs into one
// ascending run followed by a single zero terminator.
module merge_2to1_stream #(
  parameter int P_WIDTH   = 128,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  merge_2to1_stream_if.master  s,
  output logic [CNT_WIDTH-1:0] o_run_cnt
);

  localparam logic [1:0] ST_MERGE   = 2'd0;
  localparam logic [1:0] ST_DRAIN_A = 2'd1;
  localparam logic [1:0] ST_DRAIN_B = 2'd2;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic               out_vld;
  logic [P_WIDTH-1:0] out_data;

  logic               a_vld;
  logic               b_vld;
  logic               a_zero;
  logic               b_zero;
  logic               b_lt_a;

  logic               sel;
  logic               sel_term;
  logic               pop_a;
  logic               pop_b;
  logic [P_WIDTH-1:0] sel_data;

  logic               enq;
  logic               ld;
  logic               take;

  assign a_vld  = ~s.a_empty;
  assign b_vld  = ~s.b_empty;
  assign a_zero = a_vld && (s.a_data == '0);
  assign b_zero = b_vld && (s.b_data == '0);
  // Strict compare so that equal keys favour A.
  assign b_lt_a = s.b_data < s.a_data;

  assign enq  = out_vld & ~s.full & ~i_rst;
  assign ld   = ~out_vld | enq;
  assign take = sel & ld & ~i_rst;

  assign s.enq   = enq;
  assign s.data  = out_data;
  assign s.a_deq = take & pop_a;
  assign s.b_deq = take & pop_b;

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    sel       = 1'b0;
    sel_term  = 1'b0;
    pop_a     = 1'b0;
    pop_b     = 1'b0;
    sel_data  = '0;
    state_nxt = state;
    case (state)
      ST_MERGE: begin
        if (a_vld && b_vld) begin
          if (a_zero && b_zero) begin
            sel      = 1'b1;
            sel_term = 1'b1;
            pop_a    = 1'b1;
            pop_b    = 1'b1;
          end else if (a_zero) begin
            // Park A's terminator at its head; it is popped together with B's.
            state_nxt = ST_DRAIN_B;
          end else if (b_zero) begin
            state_nxt = ST_DRAIN_A;
          end else if (b_lt_a) begin
            sel      = 1'b1;
            pop_b    = 1'b1;
            sel_data = s.b_data;
          end else begin
            sel      = 1'b1;
            pop_a    = 1'b1;
            sel_data = s.a_data;
          end
        end
      end
      ST_DRAIN_B: begin
        if (b_vld) begin
          sel   = 1'b1;
          pop_b = 1'b1;
          if (b_zero) begin
            pop_a    = 1'b1;
            sel_term = 1'b1;
            if (ld) state_nxt = ST_MERGE;
          end else begin
            sel_data = s.b_data;
          end
        end
      end
      ST_DRAIN_A: begin
        if (a_vld) begin
          sel   = 1'b1;
          pop_a = 1'b1;
          if (a_zero) begin
            pop_b    = 1'b1;
            sel_term = 1'b1;
            if (ld) state_nxt = ST_MERGE;
          end else begin
            sel_data = s.a_data;
          end
        end
      end
      default: state_nxt = ST_MERGE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_MERGE;
      out_vld   <= 1'b0;
      out_data  <= '0;
      o_run_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        out_vld  <= 1'b1;
        out_data <= sel_data;
        if (sel_term) o_run_cnt <= o_run_cnt + 1'b1;
      end else if (enq) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_merge_2to1_stream.sv
// Directed bench for merge_2to1_stream: FIFO models feed queued runs, a monitor
// scores every pushed output against a queue of hand-computed expected records.
module tb_merge_2to1_stream;
  localparam int W  = 128;
  localparam int CW = 32;

  typedef logic [W-1:0] rec_t;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [CW-1:0] run_cnt;

  merge_2to1_stream_if #(.P_WIDTH(W)) s ();

  merge_2to1_stream #(.P_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .s         (s.master),
    .o_run_cnt (run_cnt)
  );

  always #5 i_clk = ~i_clk;

  rec_t qa[$];
  rec_t qb[$];
  rec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   exp_cnt = 0;

  task automatic check(input string name, input rec_t act, input rec_t req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic drive_fifos();
    s.a_empty = (qa.size() == 0);
    s.a_data  = (qa.size() != 0) ? qa[0] : '0;
    s.b_empty = (qb.size() == 0);
    s.b_data  = (qb.size() != 0) ? qb[0] : '0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic run(input rec_t va[$], input rec_t vb[$], input rec_t ve[$]);
    foreach (va[i]) qa.push_back(va[i]);
    foreach (vb[i]) qb.push_back(vb[i]);
    foreach (ve[i]) begin
      exp_q.push_back(ve[i]);
      if (ve[i] == '0) exp_cnt++;
    end
    drive_fifos();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(qa.size() == 0 && qb.size() == 0 && exp_q.size() == 0) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d records pending expected 0", name, exp_q.size());
    end
    tick();
    check({name, "_run_cnt"}, rec_t'(run_cnt), rec_t'(exp_cnt));
  endtask

  // FWFT FIFO model: pops on the edge where the DUT asserted deq.
  initial begin : fifo_model
    logic pa, pb, za, zb;
    forever begin
      @(negedge i_clk);
      pa = s.a_deq;
      pb = s.b_deq;
      za = pa && (s.a_data == '0);
      zb = pb && (s.b_data == '0);
      if (za || zb) check("zero_pair_pop", rec_t'({za, zb}), rec_t'(2'b11));
      @(posedge i_clk);
      #1;
      if (pa && qa.size() != 0) void'(qa.pop_front());
      if (pb && qb.size() != 0) void'(qb.pop_front());
      drive_fifos();
    end
  end

  initial begin : monitor
    forever begin
      @(negedge i_clk);
      if (s.enq === 1'b1) begin
        if (exp_q.size() != 0) begin
          check("out_data", s.data, exp_q.pop_front());
        end else begin
          total++;
          bad++;
          $display("FAIL out_extra: got %0d expected no output", s.data);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin : stim
    int na, nb;
    i_rst  = 1'b1;
    s.full = 1'b0;
    drive_fifos();
    @(negedge i_clk);
    check("rst_a_deq", rec_t'(s.a_deq), '0);
    check("rst_b_deq", rec_t'(s.b_deq), '0);
    tick();
    tick();
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_enq", rec_t'(s.enq), '0);
    check("rst_data", s.data, '0);
    check("rst_run_cnt", rec_t'(run_cnt), '0);
    tick();

    // Basic merge plus first-record latency.
    run('{1, 4, 7, 0}, '{2, 3, 9, 0}, '{1, 2, 3, 4, 7, 9, 0});
    @(negedge i_clk);
    check("lat_first_pop", rec_t'(s.a_deq), 1);
    check("lat_no_enq_yet", rec_t'(s.enq), 0);
    @(negedge i_clk);
    check("lat_enq", rec_t'(s.enq), 1);
    check("lat_data", s.data, 1);
    tick();
    wait_idle("merge");

    // Ties favour A; uneven runs; empty A run against a one-record B run.
    run('{5, 5, 0}, '{5, 0}, '{5, 5, 5, 0});
    run('{0}, '{8, 0}, '{8, 0});
    wait_idle("ties");

    // A drains to empty behind its terminator while B continues.
    run('{3, 0}, '{1, 6, 10, 0}, '{1, 3, 6, 10, 0});
    wait_idle("drain_b");

    // Backpressure: downstream full from the start, one record loads and holds.
    s.full = 1'b1;
    run('{1, 2, 0}, '{0}, '{1, 2, 0});
    na = 0;
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      na += int'(s.a_deq);
      nb += int'(s.b_deq);
    end
    check("bp_a_pops", rec_t'(na), 1);
    check("bp_b_pops", rec_t'(nb), 0);
    check("bp_hold_data", s.data, 1);
    check("bp_no_enq", rec_t'(s.enq), 0);
    tick();
    s.full = 1'b0;
    wait_idle("backpressure");

    // Two empty runs yield a single terminator.
    run('{0}, '{0}, '{0});
    wait_idle("empty_runs");

    // Reset while a record is held under backpressure.
    s.full = 1'b1;
    qa.push_back(4);
    qa.push_back(0);
    qb.push_back(6);
    qb.push_back(0);
    drive_fifos();
    tick();
    tick();
    tick();
    check("pre_rst_held", s.data, 4);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("mid_rst_a_deq", rec_t'(s.a_deq), '0);
    check("mid_rst_b_deq", rec_t'(s.b_deq), '0);
    tick();
    qa.delete();
    qb.delete();
    drive_fifos();
    i_rst  = 1'b0;
    s.full = 1'b0;
    exp_cnt = 0;
    @(negedge i_clk);
    check("post_rst_enq", rec_t'(s.enq), '0);
    check("post_rst_data", s.data, '0);
    check("post_rst_run_cnt", rec_t'(run_cnt), '0);
    tick();
    run('{2, 0}, '{1, 3, 0}, '{1, 2, 3, 0});
    wait_idle("after_reset");

    tick();
    check("leftover_expected", rec_t'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
